cond_inv_module: RTL and testbench

COND_INV_MODULE -- requirements
Module: cond_inv_module

---
 rtl/cond_inv_pkg.sv | 7 +
 rtl/cond_inv_core.sv | 15 +
 rtl/cond_inv_module.sv | 53 +++++
 tb/tb_cond_inv_module.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cond_inv_pkg.sv
// Shared constants for the conditional-invert register slice.
// Holds the default data width used by the core and top.
package cond_inv_pkg;

  localparam int unsigned CI_WIDTH = 8;

endpackage

// File: rtl/cond_inv_core.sv
// Combinational conditional inverter: result = in ^ {WIDTH{invert}}.
// Pure logic; all state lives in the enclosing register slice.
module cond_inv_core
  import cond_inv_pkg::*;
#(
  parameter int unsigned WIDTH = CI_WIDTH
) (
  input  logic [WIDTH-1:0] in,
  input  logic             invert,
  output logic [WIDTH-1:0] result
);

  assign result = in ^ {WIDTH{invert}};

endmodule

// File: rtl/cond_inv_module.sv
// Single-entry valid/ready register slice around cond_inv_core.
// Full throughput: a held word may be replaced in the cycle it drains.
module cond_inv_module
  import cond_inv_pkg::*;
#(
  parameter int unsigned WIDTH = CI_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             invert,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] w_result;
  logic             w_in_ready;
  logic             w_load;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;

  cond_inv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .in     (in),
    .invert (invert),
    .result (w_result)
  );

  // Slot is free when empty or being drained this same edge.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_load     = in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out       <= w_result;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_cond_inv_module.sv
// Self-checking bench: directed vectors plus a queue-based scoreboard,
// run against an 8-bit and a 13-bit instance sharing handshake stimulus.
module tb_cond_inv_module;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  d_in = '0;
  logic [4:0]  d_hi = '0;
  logic        d_inv = 1'b0;
  logic        d_vld = 1'b0;
  logic        d_ordy = 1'b0;

  logic        ir8, ov8;
  logic [7:0]  o8;
  logic        ir13, ov13;
  logic [12:0] o13;
  logic [12:0] d_in13;

  int vectors = 0;
  int errors  = 0;

  assign d_in13 = {d_hi, d_in};

  always #5 clk = ~clk;

  cond_inv_module #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in        (d_in),
    .invert    (d_inv),
    .in_valid  (d_vld),
    .in_ready  (ir8),
    .out       (o8),
    .out_valid (ov8),
    .out_ready (d_ordy)
  );

  cond_inv_module #(.WIDTH(13)) dut13 (
    .clk       (clk),
    .rst       (rst),
    .in        (d_in13),
    .invert    (d_inv),
    .in_valid  (d_vld),
    .in_ready  (ir13),
    .out       (o13),
    .out_valid (ov13),
    .out_ready (d_ordy)
  );

  // Scoreboard: a word accepted upstream must appear once, in order.
  logic [7:0]  q8[$];
  logic [12:0] q13[$];
  logic [7:0]  last8;
  logic [12:0] last13;
  bit          m_init = 1'b0;

  always @(negedge clk) begin
    if (m_init) begin
      vectors++;
      if (ov8 !== (q8.size() != 0) || ir8 !== (q8.size() == 0 || d_ordy)
          || (q8.size() != 0 && o8 !== q8[0])
          || (q8.size() == 0 && o8 !== last8)) begin
        errors++;
        $display("FAIL w8 t=%0t: out=%h v=%b rdy=%b, want out=%h v=%b",
                 $time, o8, ov8, ir8,
                 (q8.size() != 0) ? q8[0] : last8, q8.size() != 0);
      end
      vectors++;
      if (ov13 !== (q13.size() != 0) || ir13 !== (q13.size() == 0 || d_ordy)
          || (q13.size() != 0 && o13 !== q13[0])
          || (q13.size() == 0 && o13 !== last13)) begin
        errors++;
        $display("FAIL w13 t=%0t: out=%h v=%b rdy=%b, want out=%h v=%b",
                 $time, o13, ov13, ir13,
                 (q13.size() != 0) ? q13[0] : last13, q13.size() != 0);
      end
    end
    if (rst) begin
      q8.delete();
      q13.delete();
      last8  = '0;
      last13 = '0;
      m_init = 1'b1;
    end else if (m_init) begin
      bit ready_now;
      ready_now = (q8.size() == 0) || d_ordy;
      if (q8.size() != 0 && d_ordy) void'(q8.pop_front());
      if (d_vld && ready_now) begin
        last8 = d_inv ? ~d_in : d_in;
        q8.push_back(last8);
      end
      ready_now = (q13.size() == 0) || d_ordy;
      if (q13.size() != 0 && d_ordy) void'(q13.pop_front());
      if (d_vld && ready_now) begin
        last13 = d_inv ? ~d_in13 : d_in13;
        q13.push_back(last13);
      end
    end
  end

  task automatic step(input bit v, input logic [7:0] d,
                      input bit inv, input bit ordy);
    @(posedge clk);
    #1;
    d_vld  = v;
    d_in   = d;
    d_hi   = 5'($urandom);
    d_inv  = inv;
    d_ordy = ordy;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 32'(o8), 32'h00);
    chk("rst_valid", 32'(ov8), 32'h0);
    step(0, 8'h00, 0, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ir8), 32'h1);

    step(1, 8'b11001100, 0, 1);
    step(1, 8'b11001100, 1, 1);
    @(negedge clk);
    chk("pass_out", 32'(o8), 32'hCC);
    chk("pass_valid", 32'(ov8), 32'h1);
    step(1, 8'b11110000, 1, 1);
    @(negedge clk);
    chk("inv_cc", 32'(o8), 32'h33);
    step(1, 8'b10101100, 0, 1);
    @(negedge clk);
    chk("inv_f0", 32'(o8), 32'h0F);
    step(0, 8'hFF, 1, 1);
    @(negedge clk);
    chk("pass_ac", 32'(o8), 32'hAC);
    chk("pulse_hi", 32'(ov8), 32'h1);
    step(0, 8'hFF, 1, 1);
    @(negedge clk);
    chk("pulse_lo", 32'(ov8), 32'h0);
    chk("drain_keep", 32'(o8), 32'hAC);

    step(1, 8'hF0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'hAA, 1, 0);
      @(negedge clk);
      chk("bp_hold", 32'(o8), 32'h0F);
      chk("bp_ready", 32'(ir8), 32'h0);
    end
    step(1, 8'hAA, 1, 1);
    @(negedge clk);
    chk("bp_release_rdy", 32'(ir8), 32'h1);
    step(0, 8'h00, 0, 1);
    @(negedge clk);
    chk("bp_next", 32'(o8), 32'h55);
    chk("bp_next_v", 32'(ov8), 32'h1);

    step(1, 8'hCC, 1, 0);
    step(0, 8'h00, 0, 0);
    @(negedge clk);
    chk("pre_rst_out", 32'(o8), 32'h33);
    step(1, 8'hFF, 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    d_vld = 1'b0;
    @(negedge clk);
    chk("mid_rst_out", 32'(o8), 32'h00);
    chk("mid_rst_v", 32'(ov8), 32'h0);
    chk("mid_rst_rdy", 32'(ir8), 32'h1);

    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
           $urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 499) == 0);
    end
    step(0, 8'h00, 0, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
